// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
// No logic, no latency.
// No flow control of its own; it only defines widths, indices and the state encoding.
package wb_arb_pkg;

    localparam int ADR_W = 23;
    localparam int DAT_W = 8;
    localparam int CNT_W = 8;

    // Master indices, used for owner / last_owner registers
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_TIMEOUT = 2'd2
    } arb_state_e;

    // Master-side request bundle, ordered to match the slave-side output concatenation
    typedef struct packed {
        logic             cyc;
        logic             stb;
        logic             we;
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
    } wb_req_t;

endpackage

// File: rtl/wb_watchdog.sv
// Wait counter for a granted bus cycle: counts unterminated BUSY cycles.
// expired_o is registered-state derived (no combinational path from inputs).
// Holds its value once expired; clr_i has priority over en_i.
module wb_watchdog
    import wb_arb_pkg::*;
#(
    parameter int LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The current cycle is the last one allowed once LIMIT-1 cycles have already elapsed
    assign expired_o = (cnt_q == CNT_W'(LIMIT - 1));

    // Next count: clear, saturate at the expiry point, otherwise count enabled cycles
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_master_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave between two masters, with bus watchdog.
// Grant one cycle after request; slave signals and terminations pass combinationally while BUSY.
// Losing master is simply not terminated until granted; slave terminations outside BUSY are dropped.
module wb_master_arbiter
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    input  logic             m0_we_i,
    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic [DAT_W-1:0] m0_dat_i,
    output logic             m0_ack_o,
    output logic             m0_err_o,
    output logic             m0_rty_o,
    output logic [DAT_W-1:0] m0_dat_o,
    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    input  logic             m1_we_i,
    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic [DAT_W-1:0] m1_dat_i,
    output logic             m1_ack_o,
    output logic             m1_err_o,
    output logic             m1_rty_o,
    output logic [DAT_W-1:0] m1_dat_o,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    output logic             s_we_o,
    output logic [ADR_W-1:0] s_adr_o,
    output logic [DAT_W-1:0] s_dat_o,
    input  logic             s_ack_i,
    input  logic             s_err_i,
    input  logic             s_rty_i,
    input  logic [DAT_W-1:0] s_dat_i,
    output logic             busy_o,
    output logic             timeout_o
);

    arb_state_e state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_owner_q, last_owner_d;

    wb_req_t    m0_req, m1_req, own_req;
    logic       req0, req1, term;
    logic       wd_clr, wd_en, wd_expired;

    assign m0_req  = {m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i};
    assign m1_req  = {m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i};
    assign own_req = (owner_q == M1) ? m1_req : m0_req;
    assign req0    = m0_cyc_i & m0_stb_i;
    assign req1    = m1_cyc_i & m1_stb_i;
    assign term    = s_ack_i | s_err_i | s_rty_i;

    wb_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (wd_clr),
        .en_i      (wd_en),
        .expired_o (wd_expired)
    );

    // Arbitration FSM: next state, grant decision and all bus muxing
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        wd_clr       = 1'b1;
        wd_en        = 1'b0;
        s_cyc_o      = 1'b0;
        s_stb_o      = 1'b0;
        s_we_o       = 1'b0;
        s_adr_o      = '0;
        s_dat_o      = '0;
        m0_ack_o     = 1'b0;
        m0_err_o     = 1'b0;
        m0_rty_o     = 1'b0;
        m0_dat_o     = '0;
        m1_ack_o     = 1'b0;
        m1_err_o     = 1'b0;
        m1_rty_o     = 1'b0;
        m1_dat_o     = '0;
        busy_o       = (state_q != S_IDLE);
        timeout_o    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    // Contention goes to whoever did not win last; a lone requester always wins
                    owner_d      = (req0 && req1) ? ~last_owner_q : req1;
                    last_owner_d = owner_d;
                    state_d      = S_BUSY;
                end
            end
            S_BUSY: begin
                wd_clr = 1'b0;
                {s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o} = own_req;
                if (owner_q == M0) begin
                    m0_ack_o = s_ack_i;
                    m0_err_o = s_err_i;
                    m0_rty_o = s_rty_i;
                    m0_dat_o = s_dat_i;
                end else begin
                    m1_ack_o = s_ack_i;
                    m1_err_o = s_err_i;
                    m1_rty_o = s_rty_i;
                    m1_dat_o = s_dat_i;
                end
                if (term || !own_req.cyc) begin
                    state_d = S_IDLE;
                end else if (wd_expired) begin
                    state_d = S_TIMEOUT;
                end else begin
                    wd_en = 1'b1;
                end
            end
            S_TIMEOUT: begin
                timeout_o = 1'b1;
                if (owner_q == M0) begin
                    m0_err_o = 1'b1;
                end else begin
                    m1_err_o = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, owner and round-robin history registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            owner_q      <= M0;
            last_owner_q <= M1;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
        end
    end

endmodule
